dmem_resp_slave: RTL

- Word-addressed data-memory responder: the slave end of the core's load/store request/response interface.
- Accepts one request at a time over a valid/ready request channel.
- Performs a byte-strobed write or a word read on an internal memory array, then returns the result on a valid/ready response channel after a fixed, programmable latency.
- Sits below RISC_V_TOP's LSU port; serves as simulation/FPGA data memory and as the reference slave for bus verification.

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/dmem_sram_1p.sv | 28 ++
 rtl/dmem_resp_slave.sv | 103 ++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned STRB_W   = 4;
  localparam int unsigned ADDR_LSB = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Offset is taken modulo 2^32, so addresses below base land far out of range.
  function automatic logic addr_in_range(input logic [XLEN-1:0] addr,
                                         input logic [XLEN-1:0] base,
                                         input int unsigned     depth);
    logic [XLEN-1:0] off;
    off = addr - base;
    return off < XLEN'(depth * 4);
  endfunction

endpackage

// File: rtl/dmem_sram_1p.sv
// Single-port synchronous word array with per-byte write enables.
module dmem_sram_1p
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic [STRB_W-1:0] we,
  input  logic [AW-1:0]     addr,
  input  logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   rdata
);

  logic [XLEN-1:0] mem [DEPTH];

  // Read returns the pre-write contents; rdata holds until the next enabled access.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int unsigned i = 0; i < STRB_W; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_resp_slave.sv
// Word-addressed data-memory slave: valid/ready request in, fixed-latency
// valid/ready response out, one transaction in flight.
module dmem_resp_slave
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 1,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic              sclk_i,
  input  logic              srst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [XLEN-1:0]   req_addr_i,
  input  logic [XLEN-1:0]   req_wdata_i,
  input  logic [STRB_W-1:0] req_wstrb_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [XLEN-1:0]   rsp_rdata_o,
  output logic              rsp_err_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [3:0]  CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  if (LATENCY > 15) begin : g_latency_check
    $error("dmem_resp_slave: LATENCY must be 0..15");
  end

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            accept, handshake, req_err;
  logic            rd_ok_q, err_q;
  logic [AW-1:0]   mem_addr;
  logic [XLEN-1:0] sram_rdata;

  assign accept    = (state_q == IDLE) && req_ready_o && req_valid_i;
  assign handshake = (state_q == RESP) && rsp_valid_o && rsp_ready_i;
  assign req_err   = (req_addr_i[ADDR_LSB-1:0] != '0) ||
                     !addr_in_range(req_addr_i, BASE_ADDR, DEPTH);
  // BASE_ADDR is DEPTH*4 aligned, so the word index is just the low address bits of the offset.
  assign mem_addr  = req_addr_i[AW+ADDR_LSB-1:ADDR_LSB] - BASE_ADDR[AW+ADDR_LSB-1:ADDR_LSB];

  dmem_sram_1p #(.DEPTH(DEPTH)) u_sram (
    .clk   (sclk_i),
    .en    (accept && !req_err),
    .we    (req_we_i ? req_wstrb_i : '0),
    .addr  (mem_addr),
    .wdata (req_wdata_i),
    .rdata (sram_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        if (LATENCY > 0) begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
        end else begin
          state_d = RESP;
        end
      end
      WAIT: if (cnt_q == '0) state_d = RESP;
            else             cnt_d   = cnt_q - 4'd1;
      RESP: if (handshake) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered decodes of state, so rsp_valid_o trails entry into RESP by one cycle.
  always_ff @(posedge sclk_i or negedge srst_i) begin
    if (!srst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      rd_ok_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_o <= (state_q == IDLE) && !accept;
      rsp_valid_o <= (state_q == RESP) && !handshake;
      if (accept) begin
        rd_ok_q <= !req_we_i && !req_err;
        err_q   <= req_err;
      end
      if ((state_q == RESP) && !rsp_valid_o) begin
        rsp_rdata_o <= rd_ok_q ? sram_rdata : '0;
        rsp_err_o   <= err_q;
      end else if (handshake) begin
        rsp_rdata_o <= '0;
        rsp_err_o   <= 1'b0;
      end
    end
  end

endmodule
